// File: rtl/dht11_multi_ctrl.sv
// CH-channel DHT11 reader: one shared protocol FSM, round-robin poll timer or manual trigger, per-channel result/valid/err.
// Optional DHT11_DEGLITCH_EN adds a 3-sample majority filter (sampled on the 1 us tick) ahead of edge detection.
module dht11_multi_ctrl #(
    parameter int CH            = 2,
    parameter int CLK_MHZ       = 100,
    parameter int POLL_MS       = 2000,
    parameter int START_LOW_MS  = 18,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 50,
    localparam int CW           = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               reset_p,
    input  logic [CH-1:0]      dht_in,
    output logic [CH-1:0]      dht_oe,
    input  logic               auto_en,
    input  logic               start,
    input  logic [CW-1:0]      start_ch,
    output logic               busy,
    output logic [CH*32-1:0]   data_flat,
    output logic [CH-1:0]      valid,
    output logic [CH-1:0]      err,
    output logic               done,
    output logic [CW-1:0]      done_ch
);

    localparam int LOW_US   = START_LOW_MS * 1000;
    localparam int POLL_INT = POLL_MS / CH;
    localparam int DW       = $clog2(CLK_MHZ + 1);
    localparam int UMAX     = (LOW_US > TIMEOUT_US) ? LOW_US : TIMEOUT_US + 1;
    localparam int UW       = $clog2(UMAX + 2);
    localparam int PW       = $clog2(POLL_INT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
    } state_t;

    state_t           r_state, w_next;
    logic [DW-1:0]    r_div;
    logic [9:0]       r_ms;
    logic [PW-1:0]    r_poll;
    logic [CW-1:0]    r_rr, r_ch, w_acc_ch, w_pend_ch;
    logic [CH-1:0]    r_pend, w_pend_set, w_pend_clr;
    logic [CH-1:0]    r_meta, r_sync, w_filt;
    logic             r_line_d, w_line, w_fall, w_rise;
    logic [UW-1:0]    r_us;
    logic [5:0]       r_nbits;
    logic [39:0]      r_shift;
    logic             r_fail, r_done;
    logic [CW-1:0]    r_done_ch;
    logic [CH*32-1:0] r_data;
    logic [CH-1:0]    r_valid, r_err;
    logic             w_us_tick, w_ms_tick, w_poll_fire, w_start_ok, w_tmo, w_bit, w_good;
    logic             w_accept, w_from_pend, w_shift_en, w_tmo_hit, w_state_chg;
    logic [7:0]       w_sum;

    assign w_us_tick   = (r_div == DW'(CLK_MHZ - 1));
    assign w_ms_tick   = w_us_tick && (r_ms == 10'd999);
    assign w_poll_fire = auto_en && w_ms_tick && (r_poll == PW'(POLL_INT - 1));
    assign w_start_ok  = start && ({1'b0, start_ch} < (CW + 1)'(CH));

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_div  <= '0;
            r_ms   <= '0;
            r_poll <= '0;
            r_rr   <= '0;
        end else begin
            r_div <= w_us_tick ? '0 : r_div + 1'b1;
            if (w_us_tick)
                r_ms <= (r_ms == 10'd999) ? 10'd0 : r_ms + 10'd1;
            if (!auto_en)
                r_poll <= '0;
            else if (w_ms_tick)
                r_poll <= w_poll_fire ? '0 : r_poll + 1'b1;
            if (w_poll_fire)
                r_rr <= (r_rr == CW'(CH - 1)) ? '0 : r_rr + 1'b1;
        end
    end

    // Lines idle high through the pull-up, so the synchroniser resets to 1 to avoid a false first edge.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= dht_in;
            r_sync <= r_meta;
        end
    end

`ifdef DHT11_DEGLITCH_EN
    logic [CH-1:0] r_s0, r_s1, r_s2;
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_s0 <= '1;
            r_s1 <= '1;
            r_s2 <= '1;
        end else if (w_us_tick) begin
            r_s0 <= r_sync;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end
    assign w_filt = (r_s0 & r_s1) | (r_s0 & r_s2) | (r_s1 & r_s2);
`else
    assign w_filt = r_sync;
`endif

    assign w_line = w_filt[r_ch];
    assign w_fall = r_line_d & ~w_line;
    assign w_rise = ~r_line_d & w_line;
    assign w_tmo  = (r_us > UW'(TIMEOUT_US));
    assign w_bit  = (r_us > UW'(BIT_THRESH_US));
    assign w_sum  = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];
    assign w_good = !r_fail && (w_sum == r_shift[7:0]);

    always_comb begin
        w_pend_ch = '0;
        for (int k = CH - 1; k >= 0; k--)
            if (r_pend[k]) w_pend_ch = CW'(k);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_from_pend = 1'b0;
        w_acc_ch    = '0;
        w_shift_en  = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_accept = 1'b1;
                    w_acc_ch = start_ch;
                    w_next   = S_START;
                end else if (|r_pend) begin
                    w_accept    = 1'b1;
                    w_from_pend = 1'b1;
                    w_acc_ch    = w_pend_ch;
                    w_next      = S_START;
                end
            end
            S_START:     if (r_us >= UW'(LOW_US)) w_next = S_RELEASE;
            S_RELEASE:   if (w_fall) w_next = S_RESP_LOW;
                         else if (w_tmo) begin w_next = S_CHECK; w_tmo_hit = 1'b1; end
            S_RESP_LOW:  if (w_rise) w_next = S_RESP_HIGH;
                         else if (w_tmo) begin w_next = S_CHECK; w_tmo_hit = 1'b1; end
            S_RESP_HIGH: if (w_fall) w_next = S_BIT_LOW;
                         else if (w_tmo) begin w_next = S_CHECK; w_tmo_hit = 1'b1; end
            S_BIT_LOW:   if (w_rise) w_next = S_BIT_HIGH;
                         else if (w_tmo) begin w_next = S_CHECK; w_tmo_hit = 1'b1; end
            S_BIT_HIGH: begin
                if (w_fall) begin
                    w_shift_en = 1'b1;
                    w_next     = (r_nbits == 6'd39) ? S_CHECK : S_BIT_LOW;
                end else if (w_tmo) begin
                    w_next    = S_CHECK;
                    w_tmo_hit = 1'b1;
                end
            end
            S_CHECK:     w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    assign w_state_chg = (w_next != r_state);
    assign w_pend_clr  = w_from_pend ? (CH'(1) << w_acc_ch) : '0;
    assign w_pend_set  = w_poll_fire ? (CH'(1) << r_rr) : '0;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_ch      <= '0;
            r_pend    <= '0;
            r_line_d  <= 1'b1;
            r_us      <= '0;
            r_nbits   <= '0;
            r_shift   <= '0;
            r_fail    <= 1'b0;
            r_done    <= 1'b0;
            r_done_ch <= '0;
            r_data    <= '0;
            r_valid   <= '0;
            r_err     <= '0;
        end else begin
            r_done   <= 1'b0;
            r_line_d <= w_line;
            r_pend   <= (r_pend & ~w_pend_clr) | w_pend_set;
            if (w_accept) begin
                r_ch    <= w_acc_ch;
                r_fail  <= 1'b0;
                r_nbits <= '0;
            end
            // Level timer restarts on every state entry so each wait is timed independently.
            if (r_state == S_IDLE || r_state == S_CHECK || w_state_chg)
                r_us <= '0;
            else if (w_us_tick)
                r_us <= r_us + 1'b1;
            if (w_tmo_hit)
                r_fail <= 1'b1;
            if (w_shift_en) begin
                r_shift <= {r_shift[38:0], w_bit};
                r_nbits <= r_nbits + 6'd1;
            end
            if (r_state == S_CHECK) begin
                r_done    <= 1'b1;
                r_done_ch <= r_ch;
                for (int k = 0; k < CH; k++) begin
                    if (CW'(k) == r_ch) begin
                        if (w_good) begin
                            r_data[k*32 +: 32] <= r_shift[39:8];
                            r_valid[k]         <= 1'b1;
                            r_err[k]           <= 1'b0;
                        end else begin
                            r_err[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign dht_oe    = (r_state == S_START) ? (CH'(1) << r_ch) : '0;
    assign busy      = (r_state != S_IDLE);
    assign data_flat = r_data;
    assign valid     = r_valid;
    assign err       = r_err;
    assign done      = r_done;
    assign done_ch   = r_done_ch;

endmodule

// File: tb/tb_dht11_multi_ctrl.sv
// Directed bench for dht11_multi_ctrl (CH=2) with a reactive one-wire sensor model; timing is scaled down
// (2 MHz tick divider, 1 ms start pulse, 8 ms scan) so the whole run stays short.
module tb_dht11_multi_ctrl;

    localparam int TB_CLK = 2;

    logic        clk, reset_p;
    logic [1:0]  dht_in, dht_oe;
    logic        auto_en, start;
    logic [0:0]  start_ch, done_ch;
    logic        busy, done;
    logic [63:0] data_flat;
    logic [1:0]  valid, err;

    logic [1:0]  m_drv;
    logic [39:0] m_data [2];
    logic        m_silent, m_phase;
    int          mch;

    int tests, fails;
    int cyc, done_cnt, done_cyc, rel_cyc, oe0_cyc;
    int both_cnt;
    logic [0:0] last_ch;
    logic prev_oe0;
    int k, n0, d0, d1, o0, us;

    assign dht_in = ~dht_oe & m_drv;

    dht11_multi_ctrl #(
        .CH(2), .CLK_MHZ(TB_CLK), .POLL_MS(8), .START_LOW_MS(1),
        .TIMEOUT_US(200), .BIT_THRESH_US(50)
    ) dut (
        .clk(clk), .reset_p(reset_p), .dht_in(dht_in), .dht_oe(dht_oe),
        .auto_en(auto_en), .start(start), .start_ch(start_ch), .busy(busy),
        .data_flat(data_flat), .valid(valid), .err(err), .done(done), .done_ch(done_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0; done_cnt = 0; done_cyc = 0; rel_cyc = 0; oe0_cyc = 0;
        both_cnt = 0; last_ch = 1'b0; prev_oe0 = 1'b0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (dht_oe[0]) oe0_cyc = oe0_cyc + 1;
        if (prev_oe0 && !dht_oe[0]) rel_cyc = cyc;
        prev_oe0 = dht_oe[0];
        if (dht_oe == 2'b11) both_cnt = both_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            last_ch  = done_ch;
        end
    end

    task automatic us_wait(input int n);
        repeat (n * TB_CLK) @(negedge clk);
    endtask

    // Sensor: after the host pulse is released, respond 20 us later with 80/80 us, then 40 bits MSB first.
    initial begin : sensor_model
        m_drv   = 2'b11;
        m_phase = 1'b0;
        mch     = 0;
        forever begin
            wait (dht_oe != 2'b00);
            mch = dht_oe[1] ? 1 : 0;
            wait (dht_oe == 2'b00);
            if (!m_silent) begin
                us_wait(20);
                m_drv[mch] = 1'b0; us_wait(80);
                m_drv[mch] = 1'b1; us_wait(80);
                for (int i = 39; i >= 0; i--) begin
                    m_drv[mch] = 1'b0; us_wait(15);
                    m_drv[mch] = 1'b1; m_phase = 1'b1;
`ifdef DHT11_DEGLITCH_EN
                    if (i == 37 && m_data[mch][i]) begin
                        us_wait(30); m_drv[mch] = 1'b0; us_wait(1); m_drv[mch] = 1'b1; us_wait(34);
                    end else
`endif
                    us_wait(m_data[mch][i] ? 65 : 20);
                    m_phase = 1'b0;
                end
                m_drv[mch] = 1'b0; us_wait(15);
                m_drv[mch] = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start_cnt = done_cnt;
        int j = 0;
        while (done_cnt == start_cnt && j < budget) begin
            @(negedge clk);
            j++;
        end
        tests++;
        assert (done_cnt != start_cnt) else begin
            fails++;
            $error("FAIL %s: done count observed %0d expected above %0d after %0d cycles", tag, done_cnt, start_cnt, budget);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [0:0] ch);
        @(negedge clk);
        start = 1'b1; start_ch = ch;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        reset_p = 1'b1; auto_en = 1'b0; start = 1'b0; start_ch = 1'b0;
        m_silent = 1'b0;
        m_data[0] = 40'h37_00_19_05_55;
        m_data[1] = 40'h28_00_1A_03_45;
        repeat (5) @(negedge clk);
        check("rst_oe",      64'(dht_oe), 64'd0);
        check("rst_busy",    64'(busy), 64'd0);
        check("rst_data",    data_flat, 64'd0);
        check("rst_valid",   64'(valid), 64'd0);
        check("rst_err",     64'(err), 64'd0);
        check("rst_done",    64'(done), 64'd0);
        check("rst_done_ch", 64'(done_ch), 64'd0);
        reset_p = 1'b0;
        repeat (10) @(negedge clk);

        // Good read on ch0; a start while busy must be dropped.
        o0 = oe0_cyc;
        pulse_start(1'b0);
        repeat (400) @(negedge clk);
        check("t1_busy", 64'(busy), 64'd1);
        pulse_start(1'b1);
        wait_done("t1_done", 10000);
        us = (oe0_cyc - o0) / TB_CLK;
        check("t1_done_ch", 64'(last_ch), 64'd0);
        check("t1_data0",   64'(data_flat[31:0]), 64'h37001905);
        check("t1_valid",   64'(valid), 64'b01);
        check("t1_err",     64'(err), 64'b00);
        check("t1_oe_len",  64'(us >= 999 && us <= 1001), 64'd1);
        repeat (20) @(negedge clk);
        check("t1_no_queue_busy", 64'(busy), 64'd0);
        check("t1_no_queue_oe",   64'(dht_oe), 64'd0);

        // Good read on ch1, then a bad checksum on ch1.
        pulse_start(1'b1);
        wait_done("t2a_done", 10000);
        check("t2a_done_ch", 64'(last_ch), 64'd1);
        check("t2a_data1",   64'(data_flat[63:32]), 64'h28001A03);
        check("t2a_valid",   64'(valid), 64'b11);
        m_data[1] = 40'h37_00_19_05_54;
        pulse_start(1'b1);
        wait_done("t2b_done", 10000);
        check("t2b_err",   64'(err), 64'b10);
        check("t2b_valid", 64'(valid), 64'b11);
        check("t2b_data1", 64'(data_flat[63:32]), 64'h28001A03);
        check("t2b_data0", 64'(data_flat[31:0]), 64'h37001905);

        // Silent sensor on ch0: abort about 200 us after release, single done.
        m_silent = 1'b1;
        n0 = done_cnt;
        pulse_start(1'b0);
        wait_done("t3_done", 6000);
        us = (done_cyc - rel_cyc) / TB_CLK;
        check("t3_tmo_us", 64'(us >= 198 && us <= 206), 64'd1);
        check("t3_err",    64'(err), 64'b11);
        check("t3_valid",  64'(valid), 64'b11);
        check("t3_data0",  64'(data_flat[31:0]), 64'h37001905);
        repeat (400) @(negedge clk);
        check("t3_busy",     64'(busy), 64'd0);
        check("t3_done_one", 64'(done_cnt - n0), 64'd1);
        m_silent = 1'b0;

        // Auto poll: ch0 then ch1, one scan slot (4 ms) apart.
        m_data[0] = 40'h11_00_22_01_34;
        m_data[1] = 40'h33_00_1E_02_53;
        auto_en = 1'b1;
        wait_done("t4a_done", 16000);
        d0 = done_cyc;
        check("t4a_done_ch", 64'(last_ch), 64'd0);
        check("t4a_data0",   64'(data_flat[31:0]), 64'h11002201);
        wait_done("t4b_done", 11000);
        d1 = done_cyc;
        auto_en = 1'b0;
        check("t4b_done_ch",  64'(last_ch), 64'd1);
        check("t4b_data1",    64'(data_flat[63:32]), 64'h33001E02);
        check("t4b_err",      64'(err), 64'b00);
        check("t4_interval",  64'((d1 - d0) >= 7000 && (d1 - d0) <= 9000), 64'd1);
        check("t4_oe_excl",   64'(both_cnt), 64'd0);

        // Start in the same cycle as a poll expiry for ch0: manual ch1 first, then ch0.
        m_data[0] = 40'h37_00_19_05_55;
        m_data[1] = 40'h22_00_14_02_38;
        auto_en = 1'b1;
        k = 0;
        while (!dut.w_poll_fire && k < 9000) begin
            @(negedge clk);
            k++;
        end
        check("t5_fire_seen", 64'(k < 9000), 64'd1);
        start = 1'b1; start_ch = 1'b1;
        @(negedge clk);
        start = 1'b0; auto_en = 1'b0;
        wait_done("t5a_done", 10000);
        check("t5a_done_ch", 64'(last_ch), 64'd1);
        check("t5a_data1",   64'(data_flat[63:32]), 64'h22001402);
        wait_done("t5b_done", 10000);
        check("t5b_done_ch", 64'(last_ch), 64'd0);
        check("t5b_data0",   64'(data_flat[31:0]), 64'h37001905);
        check("t5_oe_excl",  64'(both_cnt), 64'd0);

        // Reset during a data bit's high phase.
        pulse_start(1'b0);
        k = 0;
        while (!m_phase && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_bit",  64'(m_phase), 64'd1);
        check("t6_busy_pre", 64'(busy), 64'd1);
        reset_p = 1'b1;
        #1;
        check("t6_oe",      64'(dht_oe), 64'd0);
        check("t6_busy",    64'(busy), 64'd0);
        check("t6_data",    data_flat, 64'd0);
        check("t6_valid",   64'(valid), 64'd0);
        check("t6_err",     64'(err), 64'd0);
        check("t6_done",    64'(done), 64'd0);
        check("t6_done_ch", 64'(done_ch), 64'd0);
        @(negedge clk);
        reset_p = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dht11_multi_ctrl.md
Name: dht11_multi_ctrl

Overview:
Parametrised N-channel DHT11 humidity/temperature reader; successor to the single-sensor DHT11 engine behind the AXI4-Lite register wrapper.
One shared protocol FSM services CH one-wire sensors, either round-robin on a poll timer or on a software trigger.
It checks the checksum, keeps per-channel result, valid and error status, and reports timeouts.
Sits under the AXI4-Lite slave; the register map reads its flattened outputs directly.

Parameters:
CH, 2, number of sensor channels (1..8)
CLK_MHZ, 100, clock frequency in MHz; sets the 1 us tick divider
POLL_MS, 2000, auto-poll period per full scan (must be >=1000)
START_LOW_MS, 18, host start-pulse low time
TIMEOUT_US, 200, max duration of any single sensor level before abort
BIT_THRESH_US, 50, high-pulse width above which a data bit is 1

Ports:
clk  in  1  system clock
reset_p  in  1  asynchronous active-high reset
dht_in  in  CH  raw sensor line level per channel (pad input)
dht_oe  out  CH  1 = drive that line low; 0 = release (pull-up)
auto_en  in  1  enable periodic round-robin polling
start  in  1  one-cycle manual trigger
start_ch  in  clog2(CH) (min 1)  channel for manual trigger
busy  out  1  FSM not IDLE
data_flat  out  CH*32  per channel {hum_i, hum_d, tmp_i, tmp_d}; channel k at [32k+31:32k]
valid  out  CH  channel holds a checksum-good result
err  out  CH  last read of channel failed (timeout or checksum)
done  out  1  one-cycle pulse at end of every read attempt
done_ch  out  clog2(CH) (min 1)  channel of the last attempt; held until the next attempt ends

Behaviour:
- Reset: dht_oe=0, busy=0, data_flat=0, valid=0, err=0, done=0, done_ch=0, poll timer=0, rr pointer=0, FSM IDLE.
- Reset is honoured mid-transaction; all lines are released within one cycle.
- Each dht_in bit passes a 2-FF synchroniser; edge detection uses the synchronised value.
- us_tick: free-running divider, one pulse every CLK_MHZ cycles. All protocol timing counts us_tick.
- Scheduling:
  - Poll timer counts ms. At POLL_MS/CH it raises a pending request for the rr pointer channel, then the pointer increments and wraps CH-1 -> 0.
  - start in IDLE is accepted the same cycle and has priority over a pending poll. The poll request stays pending.
  - start while busy is ignored; no queuing.
  - With auto_en=0 the timer holds at 0.
- FSM states:
  - IDLE: on a request, latch the channel and go to START_LOW.
  - START_LOW: dht_oe[ch]=1 for START_LOW_MS*1000 us, then go to RELEASE.
  - RELEASE: dht_oe[ch]=0. Wait for a falling edge, then go to RESP_LOW.
  - RESP_LOW: wait for a rising edge, then go to RESP_HIGH.
  - RESP_HIGH: wait for a falling edge, then go to BIT_LOW.
  - BIT_LOW: wait for a rising edge, then go to BIT_HIGH.
  - BIT_HIGH: on a falling edge, shift in bit = (high_us > BIT_THRESH_US), MSB first. After 40 bits go to CHECK, otherwise back to BIT_LOW.
  - CHECK: one cycle, then go to IDLE.
- Timeout: in any wait state the us counter resets on each state entry. If it exceeds TIMEOUT_US, go to CHECK with a fail flag.
- CHECK (success): (b0+b1+b2+b3) mod 256 == b4 and no timeout. Update data_flat for that channel, set valid[ch]=1 and err[ch]=0.
- CHECK (failure): leave data_flat and valid unchanged, set err[ch]=1.
- CHECK always pulses done for one cycle and loads done_ch.
- Only the active channel's dht_oe may be asserted; every other dht_oe bit is 0 at all times.
- Simultaneous start and poll-timer expiry: start wins; the poll request is serviced at the next IDLE.

Optional Feature:
DHT11_DEGLITCH_EN
- Defined: a 3-sample majority filter on the synchronised input, sampled every us_tick. Edges shift by up to 2 us and glitches shorter than 2 us are rejected.
- Undefined: the synchronised signal is used directly.
- Bit thresholds are unchanged in both builds.

Test Plan:
- Sensor model on ch0 returns 0x37,0x00,0x19,0x05,0x55 after a manual start -> done with done_ch=0; data_flat[31:0]=0x37001905; valid[0]=1; err[0]=0; dht_oe[0] low-drive measured at 18000 us +/-1.
- Model sends a bad checksum 0x54 on ch1 after a previous good read -> err[1]=1, valid[1] stays 1, data_flat[63:32] unchanged.
- Model silent after the start pulse -> timeout about 200 us after release; err=1; busy drops; done pulses once.
- auto_en=1, CH=2, POLL_MS=2000 -> reads alternate ch0, ch1 at 1000 ms intervals; dht_oe is never asserted on both channels at once.
- start asserted in the same cycle as poll expiry -> manual channel is read first, the polled channel next. Reset asserted during BIT_HIGH -> all outputs return to reset values and dht_oe=0 immediately.
- With DHT11_DEGLITCH_EN, a 1 us low glitch during a data bit's high phase -> decoded data is unchanged and the checksum passes.
